// File: rtl/stopwatch_bcd_if.sv
// Button inputs and BCD display outputs of the stopwatch.
// The slave side is the stopwatch; the master side drives the buttons and reads the digits.
interface stopwatch_bcd_if;
  logic       btn_start;
  logic       btn_clear;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic       running;
  logic       wrap;

  modport master (
    output btn_start,
    output btn_clear,
    input  dig0,
    input  dig1,
    input  dig2,
    input  dig3,
    input  running,
    input  wrap
  );

  modport slave (
    input  btn_start,
    input  btn_clear,
    output dig0,
    output dig1,
    output dig2,
    output dig3,
    output running,
    output wrap
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// SS.hh BCD stopwatch (00.00..59.99) with start/pause/resume and clear from button levels.
// All outputs are registered; reset is synchronous and active-high.
module stopwatch_bcd #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input logic            clk,
  input logic            rst,
  stopwatch_bcd_if.slave bus
);

  localparam int unsigned Div    = CLK_HZ / TICK_HZ;
  localparam int unsigned PrescW = $clog2(Div);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e            state_q;
  logic [PrescW-1:0] presc_q;
  logic [3:0]        dig0_q, dig1_q, dig2_q, dig3_q;
  logic              running_q, wrap_q;
  logic              start_prev_q, clear_prev_q;
  // Low for the first cycle after reset so a button held through reset release gives no edge.
  logic              armed_q;

  logic       start_edge, clear_edge, tick;
  logic [3:0] dig0_d, dig1_d, dig2_d, dig3_d;
  logic       wrap_d;

  assign start_edge = bus.btn_start & ~start_prev_q & armed_q;
  assign clear_edge = bus.btn_clear & ~clear_prev_q & armed_q;
  assign tick       = (state_q == StRun) && (presc_q == PrescW'(Div - 1));

  // BCD ripple carry; >= comparisons keep any out-of-range digit recovering to 0.
  always_comb begin
    dig0_d = dig0_q;
    dig1_d = dig1_q;
    dig2_d = dig2_q;
    dig3_d = dig3_q;
    wrap_d = 1'b0;
    if (tick) begin
      if (dig0_q >= 4'd9) begin
        dig0_d = 4'd0;
        if (dig1_q >= 4'd9) begin
          dig1_d = 4'd0;
          if (dig2_q >= 4'd9) begin
            dig2_d = 4'd0;
            if (dig3_q >= 4'd5) begin
              dig3_d = 4'd0;
              wrap_d = 1'b1;
            end else begin
              dig3_d = dig3_q + 4'd1;
            end
          end else begin
            dig2_d = dig2_q + 4'd1;
          end
        end else begin
          dig1_d = dig1_q + 4'd1;
        end
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      dig0_q       <= 4'd0;
      dig1_q       <= 4'd0;
      dig2_q       <= 4'd0;
      dig3_q       <= 4'd0;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      start_prev_q <= bus.btn_start;
      clear_prev_q <= bus.btn_clear;
      armed_q      <= 1'b1;
      wrap_q       <= 1'b0;
      if (clear_edge) begin
        state_q   <= StIdle;
        presc_q   <= '0;
        dig0_q    <= 4'd0;
        dig1_q    <= 4'd0;
        dig2_q    <= 4'd0;
        dig3_q    <= 4'd0;
        running_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            presc_q <= '0;
            dig0_q  <= 4'd0;
            dig1_q  <= 4'd0;
            dig2_q  <= 4'd0;
            dig3_q  <= 4'd0;
            if (start_edge) begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          StRun: begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            dig3_q  <= dig3_d;
            wrap_q  <= wrap_d;
            if (start_edge) begin
              state_q   <= StPause;
              running_q <= 1'b0;
            end
          end
          StPause: begin
            if (start_edge) begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dig0    = dig0_q;
  assign bus.dig1    = dig1_q;
  assign bus.dig2    = dig2_q;
  assign bus.dig3    = dig3_q;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with DIV = 10; inputs change and outputs are read 1 ns
// after each rising edge.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  stopwatch_bcd_if sw ();

  stopwatch_bcd #(
    .CLK_HZ (10),
    .TICK_HZ(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sw)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] digits, input logic run,
                           input logic wr);
    check({tag, ".digits"}, {sw.dig3, sw.dig2, sw.dig1, sw.dig0}, digits);
    check({tag, ".running"}, {15'd0, sw.running}, {15'd0, run});
    check({tag, ".wrap"}, {15'd0, sw.wrap}, {15'd0, wr});
  endtask

  task automatic press_start();
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
  endtask

  task automatic press_clear();
    sw.btn_clear = 1'b1;
    step(1);
    sw.btn_clear = 1'b0;
  endtask

  initial begin
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;

    // Reset held 3 cycles with random buttons
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sw.btn_start = 1'($urandom_range(0, 1));
      sw.btn_clear = 1'($urandom_range(0, 1));
      step(1);
    end
    check_all("reset", 16'h0000, 1'b0, 1'b0);
    rst          = 1'b0;
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    step(1);
    check_all("post_reset", 16'h0000, 1'b0, 1'b0);

    // Basic count: RUN one cycle after the edge, dig0 every 10 cycles
    press_start();
    check_all("run_entry", 16'h0000, 1'b1, 1'b0);
    step(9);
    check_all("before_tick1", 16'h0000, 1'b1, 1'b0);
    step(1);
    check_all("tick1", 16'h0001, 1'b1, 1'b0);
    for (int i = 2; i <= 25; i++) begin
      step(10);
      check("count", {sw.dig3, sw.dig2, sw.dig1, sw.dig0}, 16'(((i / 10) << 4) | (i % 10)));
    end
    check_all("count25", 16'h0025, 1'b1, 1'b0);
    press_clear();
    check_all("clear1", 16'h0000, 1'b0, 1'b0);
    step(3);
    check_all("idle_hold", 16'h0000, 1'b0, 1'b0);

    // Pause/resume: pause with prescaler at 5, so 5 run cycles to the next tick
    press_start();
    step(14);
    check_all("pre_pause", 16'h0001, 1'b1, 1'b0);
    press_start();
    check_all("pause", 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(10);
      check_all("paused", 16'h0001, 1'b0, 1'b0);
    end
    press_start();
    check_all("resume", 16'h0001, 1'b1, 1'b0);
    step(4);
    check_all("resume_4", 16'h0001, 1'b1, 1'b0);
    step(1);
    check_all("resume_5", 16'h0002, 1'b1, 1'b0);
    step(10);
    check_all("resume_15", 16'h0003, 1'b1, 1'b0);
    press_clear();
    check_all("clear2", 16'h0000, 1'b0, 1'b0);

    // Rollover 59.99 -> 00.00 with a single-cycle wrap
    press_start();
    step(10 * 5999);
    check_all("at_5999", 16'h5999, 1'b1, 1'b0);
    step(9);
    check_all("pre_wrap", 16'h5999, 1'b1, 1'b0);
    step(1);
    check_all("wrap", 16'h0000, 1'b1, 1'b1);
    step(1);
    check_all("post_wrap", 16'h0000, 1'b1, 1'b0);
    step(9);
    check_all("after_wrap_tick", 16'h0001, 1'b1, 1'b0);
    press_clear();
    check_all("clear3", 16'h0000, 1'b0, 1'b0);

    // Clear wins over a simultaneous start; held buttons give no further edges
    press_start();
    step(3470);
    check_all("at_0347", 16'h0347, 1'b1, 1'b0);
    sw.btn_start = 1'b1;
    sw.btn_clear = 1'b1;
    step(1);
    check_all("clear_priority", 16'h0000, 1'b0, 1'b0);
    step(20);
    check_all("held_both", 16'h0000, 1'b0, 1'b0);
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    step(1);

    // Reset mid-run with start held through reset release
    press_start();
    step(12340);
    check_all("at_1234", 16'h1234, 1'b1, 1'b0);
    sw.btn_start = 1'b1;
    rst          = 1'b1;
    step(2);
    check_all("mid_reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);
    check_all("release_1", 16'h0000, 1'b0, 1'b0);
    step(5);
    check_all("held_start", 16'h0000, 1'b0, 1'b0);
    sw.btn_start = 1'b0;
    step(1);
    check_all("start_low", 16'h0000, 1'b0, 1'b0);
    press_start();
    check_all("restart", 16'h0000, 1'b1, 1'b0);
    step(10);
    check_all("restart_tick", 16'h0001, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
